// File: rtl/hazard_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_flush_ctrl
// Description : Stall/flush controller for the IF/ID, ID/EX and EX/MEM
//               pipeline registers. It covers load-use hazards, taken
//               branches, memory-busy freeze with timeout, and the
//               multi-cycle drain after a trap or mret.
//               Optional macro HAZARD_PERF_EN builds saturating counters
//               for stall cycles and flush events.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_flush_ctrl #(
    parameter int TRAP_FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT       = 255,
    parameter int CNT_W             = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdE,
    input  logic             MemReadE,
    input  logic             RegWriteE,
    input  logic             PCSrcE,
    input  logic             TrapM,
    input  logic             MemBusyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             TrapRedirect,
    output logic             BusTimeout,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushEvents
);

    localparam int c_WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam int c_TRAP_W = (TRAP_FLUSH_CYCLES > 1) ? $clog2(TRAP_FLUSH_CYCLES) : 1;

    localparam logic [c_WAIT_W-1:0] c_WAIT_LIMIT  = c_WAIT_W'(MEM_TIMEOUT);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE    = c_WAIT_W'(1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX    = '1;
    localparam logic [c_TRAP_W-1:0] c_TRAP_RELOAD = c_TRAP_W'(TRAP_FLUSH_CYCLES - 1);
    localparam logic [c_TRAP_W-1:0] c_TRAP_ONE    = c_TRAP_W'(1);
    localparam bit                  c_TIMEOUT_EN  = (MEM_TIMEOUT != 0);
    localparam bit                  c_TRAP_SEQ    = (TRAP_FLUSH_CYCLES > 1);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_MEM_WAIT   = 2'd1,
        ST_TRAP_FLUSH = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_WAIT_W-1:0] r_waitcnt;
    logic [c_WAIT_W-1:0] w_waitcnt_nxt;
    logic [c_TRAP_W-1:0] r_trapcnt;
    logic [c_TRAP_W-1:0] w_trapcnt_nxt;
    logic                r_bus_timeout;
    logic                w_timeout_hit;

    logic w_load_use;
    logic w_stall_f;
    logic w_stall_d;
    logic w_stall_e;
    logic w_stall_m;
    logic w_flush_d;
    logic w_flush_e;
    logic w_flush_m;
    logic w_trap_redirect;

    // x0 is never a real producer, so a load targeting it cannot cause a hazard
    assign w_load_use = MemReadE & RegWriteE & (RdE != 5'd0) &
                        ((RdE == Rs1D) | (RdE == Rs2D));

    // Next-state and zero-latency stall/flush decode; TrapM outranks everything in every state
    always_comb begin
        w_state_nxt     = r_state;
        w_waitcnt_nxt   = r_waitcnt;
        w_trapcnt_nxt   = r_trapcnt;
        w_timeout_hit   = 1'b0;
        w_stall_f       = 1'b0;
        w_stall_d       = 1'b0;
        w_stall_e       = 1'b0;
        w_stall_m       = 1'b0;
        w_flush_d       = 1'b0;
        w_flush_e       = 1'b0;
        w_flush_m       = 1'b0;
        w_trap_redirect = 1'b0;

        if (rst) begin
            w_flush_d     = 1'b1;
            w_flush_e     = 1'b1;
            w_flush_m     = 1'b1;
            w_state_nxt   = ST_RUN;
            w_waitcnt_nxt = '0;
            w_trapcnt_nxt = '0;
        end else if (TrapM) begin
            // Trap/mret commit: empty every younger stage and redirect the PC
            w_flush_d       = 1'b1;
            w_flush_e       = 1'b1;
            w_flush_m       = 1'b1;
            w_trap_redirect = 1'b1;
            w_waitcnt_nxt   = '0;
            if (c_TRAP_SEQ) begin
                w_state_nxt   = ST_TRAP_FLUSH;
                w_trapcnt_nxt = c_TRAP_RELOAD;
            end else begin
                w_state_nxt   = ST_RUN;
                w_trapcnt_nxt = '0;
            end
        end else begin
            case (r_state)
                ST_TRAP_FLUSH: begin
                    // Drain: Memory stage was already emptied on entry, so busy is moot
                    w_flush_d = 1'b1;
                    w_flush_e = 1'b1;
                    if (r_trapcnt <= c_TRAP_ONE) begin
                        w_trapcnt_nxt = '0;
                        w_state_nxt   = ST_RUN;
                    end else begin
                        w_trapcnt_nxt = r_trapcnt - c_TRAP_ONE;
                    end
                end
                default: begin
                    if (MemBusyM) begin
                        w_stall_f = 1'b1;
                        w_stall_d = 1'b1;
                        w_stall_e = 1'b1;
                        w_stall_m = 1'b1;
                        if (r_state == ST_RUN) begin
                            w_state_nxt   = ST_MEM_WAIT;
                            w_waitcnt_nxt = c_WAIT_ONE;
                        end else if (c_TIMEOUT_EN && (r_waitcnt == c_WAIT_LIMIT)) begin
                            // Give up on the access; the pulse is seen next cycle
                            w_timeout_hit = 1'b1;
                            w_state_nxt   = ST_RUN;
                            w_waitcnt_nxt = '0;
                        end else if (r_waitcnt != c_WAIT_MAX) begin
                            w_waitcnt_nxt = r_waitcnt + c_WAIT_ONE;
                        end
                    end else begin
                        w_state_nxt   = ST_RUN;
                        w_waitcnt_nxt = '0;
                        if (PCSrcE) begin
                            // Wrong-path instructions in D and E are squashed
                            w_flush_d = 1'b1;
                            w_flush_e = 1'b1;
                        end else if (w_load_use) begin
                            // Hold F/D one cycle and insert a bubble into E
                            w_stall_f = 1'b1;
                            w_stall_d = 1'b1;
                            w_flush_e = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // State, counter and timeout-pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_waitcnt     <= '0;
            r_trapcnt     <= '0;
            r_bus_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_waitcnt     <= w_waitcnt_nxt;
            r_trapcnt     <= w_trapcnt_nxt;
            r_bus_timeout <= w_timeout_hit;
        end
    end

    assign StallF       = w_stall_f;
    assign StallD       = w_stall_d;
    assign StallE       = w_stall_e;
    assign StallM       = w_stall_m;
    assign FlushD       = w_flush_d;
    assign FlushE       = w_flush_e;
    assign FlushM       = w_flush_m;
    assign TrapRedirect = w_trap_redirect;
    // Masked so the pulse reads 0 throughout reset, including the first cycle
    assign BusTimeout   = r_bus_timeout & ~rst;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_events;

    // Saturating performance counters; reset-induced flushes are not counted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (w_stall_f && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (w_flush_e && (r_flush_events != '1)) begin
                r_flush_events <= r_flush_events + 1'b1;
            end
        end
    end

    assign StallCycles = r_stall_cycles;
    assign FlushEvents = r_flush_events;
`else
    assign StallCycles = '0;
    assign FlushEvents = '0;
`endif

endmodule
`default_nettype wire
